board_state: RTL

- Holds the authoritative 8x8 chess board and drives the boardPos array consumed by the VGA stage.
- Accepts one move command at a time over a valid/ready handshake.
- Each move is validated for occupancy, turn and own-piece capture, then committed with a read-check-write FSM.
- Reports completion, any captured piece, and the side to move.

---
 rtl/chess_pkg.sv | 33 +++
 rtl/move_checker.sv | 16 +
 rtl/board_state.sv | 131 +++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: piece encoding, board types, start position and FSM states shared by the board logic
package chess_pkg;
    typedef struct packed {
        logic       occ;
        logic       colour;
        logic [2:0] ptype;
    } piece_t;
    typedef logic [5:0] square_t;
    typedef piece_t [7:0][7:0] board_t;
    typedef enum logic [2:0] {IDLE, READ, CHECK, WAIT_VBL, WRITE, DONE} state_t;
    localparam piece_t     PIECE_EMPTY = '0;
    localparam logic [2:0] PAWN        = 3'd1;
    localparam logic [2:0] KNIGHT      = 3'd2;
    localparam logic [2:0] BISHOP      = 3'd3;
    localparam logic [2:0] ROOK        = 3'd4;
    localparam logic [2:0] QUEEN       = 3'd5;
    localparam logic [2:0] KING        = 3'd6;
    // black on rows 0-1 at the top of the screen, white on rows 6-7
    function automatic board_t start_board();
        logic [7:0][2:0] back;
        board_t          b;
        back = {ROOK, KNIGHT, BISHOP, KING, QUEEN, BISHOP, KNIGHT, ROOK};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c[2:0]] = {2'b11, back[c[2:0]]};
            b[1][c[2:0]] = {2'b11, PAWN};
            b[6][c[2:0]] = {2'b10, PAWN};
            b[7][c[2:0]] = {2'b10, back[c[2:0]]};
        end
        return b;
    endfunction
    localparam board_t START_BOARD = start_board();
endpackage

// File: rtl/move_checker.sv
// move_checker: combinational rejection of a move from its source/destination pieces, side to move and squares
module move_checker
    import chess_pkg::*;
(
    input  piece_t  src_i,
    input  piece_t  dst_i,
    input  logic    white_to_move_i,
    input  square_t from_i,
    input  square_t to_i,
    output logic    err_o
);
    assign err_o = ~src_i.occ
                 | (src_i.colour == white_to_move_i)
                 | (dst_i.occ & (dst_i.colour == src_i.colour))
                 | (from_i == to_i);
endmodule

// File: rtl/board_state.sv
// board_state: authoritative chess board with a read-check-write move FSM; define BOARD_VBLANK_SYNC_EN to commit writes only in vertical blanking
module board_state
    import chess_pkg::*;
#(
    parameter bit         START_WHITE  = 1'b1,
    parameter logic [2:0] PROMOTE_TYPE = 3'd5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init_req_i,
    input  logic                 move_valid_i,
    output logic                 move_ready_o,
    input  logic [5:0]           move_from_i,
    input  logic [5:0]           move_to_i,
    input  logic                 vsync_i,
    output logic [7:0][7:0][4:0] board_pos_o,
    output logic                 move_done_o,
    output logic                 move_err_o,
    output logic [4:0]           captured_o,
    output logic                 white_to_move_o
);
    state_t  state_q, state_d;
    board_t  board_q, board_d;
    logic    wtm_q, wtm_d;
    square_t from_q, from_d, to_q, to_d;
    piece_t  src_q, src_d, dst_q, dst_d, cap_q, cap_d;
    logic    err_q, err_d;
    logic    chk_err, vbl_go, promote;
    piece_t  moved;

    move_checker u_checker (
        .src_i          (src_q),
        .dst_i          (dst_q),
        .white_to_move_i(wtm_q),
        .from_i         (from_q),
        .to_i           (to_q),
        .err_o          (chk_err)
    );

`ifdef BOARD_VBLANK_SYNC_EN
    logic vsync_q;
    // remember last vsync level so WAIT_VBL can spot the falling edge
    always_ff @(posedge clk) begin
        vsync_q <= reset ? 1'b1 : vsync_i;
    end
    assign vbl_go = vsync_q & ~vsync_i;
`else
    logic unused_vsync;
    assign unused_vsync = vsync_i;
    assign vbl_go       = 1'b1;
`endif

    assign promote = (src_q.ptype == PAWN) && (to_q[5:3] == (src_q.colour ? 3'd7 : 3'd0));
    assign moved   = promote ? piece_t'({1'b1, src_q.colour, PROMOTE_TYPE}) : src_q;

    // next-state, board update and move bookkeeping
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        wtm_d   = wtm_q;
        from_d  = from_q;
        to_d    = to_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cap_d   = cap_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (init_req_i) begin
                    board_d = START_BOARD;
                    wtm_d   = START_WHITE;
                end else if (move_valid_i) begin
                    from_d  = move_from_i;
                    to_d    = move_to_i;
                    state_d = READ;
                end
            end
            READ: begin
                src_d   = board_q[from_q[5:3]][from_q[2:0]];
                dst_d   = board_q[to_q[5:3]][to_q[2:0]];
                state_d = CHECK;
            end
            CHECK: begin
                err_d   = chk_err;
                state_d = chk_err ? DONE : WAIT_VBL;
            end
            WAIT_VBL: state_d = vbl_go ? WRITE : WAIT_VBL;
            WRITE: begin
                board_d[from_q[5:3]][from_q[2:0]] = PIECE_EMPTY;
                board_d[to_q[5:3]][to_q[2:0]]     = moved;
                cap_d   = dst_q;
                wtm_d   = ~wtm_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any move in flight and restores the start position
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            board_q <= START_BOARD;
            wtm_q   <= START_WHITE;
            from_q  <= '0;
            to_q    <= '0;
            src_q   <= PIECE_EMPTY;
            dst_q   <= PIECE_EMPTY;
            cap_q   <= PIECE_EMPTY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            wtm_q   <= wtm_d;
            from_q  <= from_d;
            to_q    <= to_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    assign move_ready_o    = state_q == IDLE;
    assign move_done_o     = state_q == DONE;
    assign move_err_o      = move_done_o & err_q;
    assign captured_o      = (move_done_o & ~err_q) ? cap_q : PIECE_EMPTY;
    assign white_to_move_o = wtm_q;
    assign board_pos_o     = board_q;
endmodule
